// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling, LSB-first data,
// optional parity and one stop bit; reports each frame with a one-cycle done pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int NUM_DATA_BITS = 8,
  parameter int PARITY_EN     = 1,
  parameter int PARITY_ODD    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     rx,
  output logic [NUM_DATA_BITS-1:0] data,
  output logic                     done,
  output logic                     busy,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_expect(input logic [NUM_DATA_BITS-1:0] w);
    return (PARITY_ODD != 0) ? ~^w : ^w;
  endfunction

  state_t                   state_q, state_d;
  logic [CW-1:0]            clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]            bit_idx_q, bit_idx_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
  logic [NUM_DATA_BITS-1:0] data_q, data_d;
  logic                     perr_lat_q, perr_lat_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     parity_err_q, parity_err_d;
  logic                     frame_err_q, frame_err_d;
  logic                     error_q, error_d;
  logic                     rx_meta_q, rs_q, rx_prev_q;

  // Synchronizer keeps running while disabled; only reset forces it to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
      rx_prev_q <= rs_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      perr_lat_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      perr_lat_q   <= perr_lat_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    perr_lat_d   = perr_lat_q;
    done_d       = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    error_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a fresh 1->0 edge starts a frame, so a held-low line never retriggers.
        if (rx_prev_q && !rs_q) begin
          state_d    = ST_START;
          clk_cnt_d  = '0;
          bit_idx_d  = '0;
          perr_lat_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rs_q ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rs_q;
          if (bit_idx_q == LAST_IDX) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d  = '0;
          perr_lat_d = (rs_q != parity_expect(shift_q));
          state_d    = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d    = '0;
          done_d       = 1'b1;
          data_d       = shift_q;
          parity_err_d = perr_lat_q;
          frame_err_d  = !rs_q;
          error_d      = perr_lat_q || !rs_q;
          state_d      = ST_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign data       = data_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign error      = error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit: an even-parity and an odd-parity
// receiver share one rx line; each task checks its own expected values.
module tb_uart_rx;
  localparam int CPB = 16;
  // rx falls at cycle s; edge seen at s+2; done at s+2+CPB/2+10*CPB+1
  localparam int DONE_LAT = 2 + CPB / 2 + 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data, data2;
  logic       done, busy, perr, ferr, err;
  logic       done2, busy2, perr2, ferr2, err2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_hi = 0;
  int frame_start = 0;

  int         n_done = 0;
  int         d_cyc [64];
  logic [7:0] d_data[64];
  logic       d_perr[64];
  logic       d_ferr[64];
  logic       d_err [64];
  int         n_done2 = 0;
  logic [7:0] d2_data = 8'h00;
  logic       d2_err = 1'b0;
  logic       d2_perr = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(CPB), .NUM_DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx), .data(data), .done(done),
    .busy(busy), .parity_err(perr), .frame_err(ferr), .error(err));

  uart_rx #(.CLKS_PER_BIT(CPB), .NUM_DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx), .data(data2), .done(done2),
    .busy(busy2), .parity_err(perr2), .frame_err(ferr2), .error(err2));

  always @(negedge clk) begin
    if (done) begin
      d_cyc[n_done % 64]  <= cyc;
      d_data[n_done % 64] <= data;
      d_perr[n_done % 64] <= perr;
      d_ferr[n_done % 64] <= ferr;
      d_err[n_done % 64]  <= err;
      n_done <= n_done + 1;
    end
    if (done2) begin
      d2_data <= data2;
      d2_err  <= err2;
      d2_perr <= perr2;
      n_done2 <= n_done2 + 1;
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    frame_start = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(par, CPB);
    drive_bit(stp, CPB);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({perr, ferr, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {perr, ferr, err}); end
    checks++; if ({data2, busy2} !== 9'h000) begin errors++; $display("FAIL reset_odd got %h exp 000", {data2, busy2}); end
    reset = 1'b0;
    drive_bit(1'b1, 10);
  endtask

  task automatic test_basic();
    int base = n_done;
    int fs;
    busy_hi = 0;
    send_frame(8'hA5, 1'b0, 1'b1);
    fs = frame_start;
    drive_bit(1'b1, 10);
    checks++; if (n_done - base !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", n_done - base); end
    checks++; if (d_cyc[base % 64] !== fs + DONE_LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", d_cyc[base % 64], fs + DONE_LAT); end
    checks++; if (d_data[base % 64] !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", d_data[base % 64]); end
    checks++; if ({d_perr[base % 64], d_ferr[base % 64], d_err[base % 64]} !== 3'b000) begin
      errors++; $display("FAIL basic_flags got %b exp 000", {d_perr[base % 64], d_ferr[base % 64], d_err[base % 64]}); end
    checks++; if (busy_hi !== 168) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 168", busy_hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_parity();
    int base = n_done;
    int base2;
    send_frame(8'hA5, 1'b1, 1'b1);
    drive_bit(1'b1, 10);
    checks++; if (n_done - base !== 1) begin errors++; $display("FAIL par_count got %0d exp 1", n_done - base); end
    checks++; if (d_data[base % 64] !== 8'hA5) begin errors++; $display("FAIL par_data got %h exp a5", d_data[base % 64]); end
    checks++; if ({d_perr[base % 64], d_ferr[base % 64], d_err[base % 64]} !== 3'b101) begin
      errors++; $display("FAIL par_flags got %b exp 101", {d_perr[base % 64], d_ferr[base % 64], d_err[base % 64]}); end
    base  = n_done;
    base2 = n_done2;
    send_frame(8'h00, 1'b1, 1'b1);
    drive_bit(1'b1, 10);
    checks++; if (n_done2 - base2 !== 1) begin errors++; $display("FAIL odd_count got %0d exp 1", n_done2 - base2); end
    checks++; if ({d2_data, d2_perr, d2_err} !== 10'h000) begin errors++; $display("FAIL odd_result got %h exp 000", {d2_data, d2_perr, d2_err}); end
    checks++; if (d_perr[base % 64] !== 1'b1) begin errors++; $display("FAIL even_on_odd_frame got %b exp 1", d_perr[base % 64]); end
  endtask

  task automatic test_frame_err();
    int base = n_done;
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 40);
    checks++; if (n_done - base !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", n_done - base); end
    checks++; if (d_data[base % 64] !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h exp 3c", d_data[base % 64]); end
    checks++; if ({d_perr[base % 64], d_ferr[base % 64], d_err[base % 64]} !== 3'b011) begin
      errors++; $display("FAIL ferr_flags got %b exp 011", {d_perr[base % 64], d_ferr[base % 64], d_err[base % 64]}); end
    base = n_done;
    send_frame(8'h55, 1'b0, 1'b1);
    drive_bit(1'b1, 10);
    checks++; if (n_done - base !== 1) begin errors++; $display("FAIL after_ferr_count got %0d exp 1", n_done - base); end
    checks++; if ({d_data[base % 64], d_err[base % 64]} !== 9'h0AA) begin
      errors++; $display("FAIL after_ferr_word got %h exp 0aa", {d_data[base % 64], d_err[base % 64]}); end
  endtask

  task automatic test_glitch();
    int base = n_done;
    busy_hi = 0;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 6);
    checks++; if (busy_hi !== 8) begin errors++; $display("FAIL glitch_busy_cycles got %0d exp 8", busy_hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_t9 got %b exp 0", busy); end
    drive_bit(1'b1, 200);
    checks++; if (n_done - base !== 0) begin errors++; $display("FAIL glitch_done got %0d exp 0", n_done - base); end
  endtask

  task automatic test_back_to_back();
    int base = n_done;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    drive_bit(1'b1, 10);
    checks++; if (n_done - base !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", n_done - base); end
    checks++; if (d_cyc[(base + 1) % 64] - d_cyc[base % 64] !== 11 * CPB) begin
      errors++; $display("FAIL b2b_spacing got %0d exp %0d", d_cyc[(base + 1) % 64] - d_cyc[base % 64], 11 * CPB); end
    checks++; if ({d_data[base % 64], d_data[(base + 1) % 64]} !== 16'h01FE) begin
      errors++; $display("FAIL b2b_data got %h exp 01fe", {d_data[base % 64], d_data[(base + 1) % 64]}); end
    checks++; if ({d_err[base % 64], d_err[(base + 1) % 64]} !== 2'b00) begin
      errors++; $display("FAIL b2b_err got %b exp 00", {d_err[base % 64], d_err[(base + 1) % 64]}); end
  endtask

  task automatic test_abort(input bit via_enable);
    int base = n_done;
    logic [7:0] v = 8'hC3;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(v[i], CPB);
    drive_bit(v[4], CPB / 2);
    if (via_enable) enable = 1'b0;
    else            reset  = 1'b1;
    @(negedge clk);
    checks++; if ({data, done, busy, perr, ferr, err} !== 13'h0000) begin
      errors++; $display("FAIL abort_outputs en=%0d got %h exp 0000", via_enable, {data, done, busy, perr, ferr, err}); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    reset  = 1'b0;
    drive_bit(1'b1, 200);
    checks++; if (n_done - base !== 0) begin errors++; $display("FAIL abort_done en=%0d got %0d exp 0", via_enable, n_done - base); end
    send_frame(8'h81, 1'b0, 1'b1);
    drive_bit(1'b1, 10);
    checks++; if (n_done - base !== 1) begin errors++; $display("FAIL abort_next_count en=%0d got %0d exp 1", via_enable, n_done - base); end
    checks++; if ({d_data[base % 64], d_err[base % 64]} !== 9'h102) begin
      errors++; $display("FAIL abort_next_word en=%0d got %h exp 102", via_enable, {d_data[base % 64], d_err[base % 64]}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
